ps2_host_cmd_ctrl: RTL and testbench

Host-side command sequencer for the PS/2 keyboard port. It takes one command byte plus an optional argument byte from the system, for example ED plus an LED mask. It performs the host-to-device PS/2 transmission on the open-drain clock and data lines, then waits for the keyboard response from the existing receive path. It owns the bus: the receiver is disabled while the host transmits, and resend and timeout handling is done here.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_line_sync.sv | 41 ++++
 rtl/ps2_host_cmd_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_ps2_host_cmd_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller states, protocol bytes, status codes and frame builder.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    TX_BITS,
    WAIT_LINEACK,
    WAIT_RESP,
    FINISH
  } ps2_state_e;

  localparam logic [7:0] PS2_ACK         = 8'hFA;
  localparam logic [7:0] PS2_RESEND      = 8'hFE;
  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;

  typedef logic [1:0] ps2_err_t;

  localparam ps2_err_t ERR_OK        = 2'b00;
  localparam ps2_err_t ERR_TIMEOUT   = 2'b01;
  localparam ps2_err_t ERR_RETRY     = 2'b10;
  localparam ps2_err_t ERR_NOLINEACK = 2'b11;

  // Host-to-device frame, index 0 sent first: data LSB first, odd parity, stop.
  function automatic logic [9:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~(^b), b};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines with a registered clock-fall strobe.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic dat_sync,
  output logic clk_fall
);

  logic [1:0] clk_pipe_q, clk_pipe_d;
  logic [1:0] dat_pipe_q, dat_pipe_d;
  logic       clk_prev_q, clk_prev_d;
  logic       fall_q, fall_d;

  always_comb begin
    clk_pipe_d = {clk_pipe_q[0], ps2_clk_in};
    dat_pipe_d = {dat_pipe_q[0], ps2_dat_in};
    clk_prev_d = clk_pipe_q[1];
    fall_d     = clk_prev_q & ~clk_pipe_q[1];
  end

  // Idle PS/2 lines float high, so the pipeline resets to 1 to avoid a false fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_pipe_q <= 2'b11;
      dat_pipe_q <= 2'b11;
      clk_prev_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_pipe_q <= clk_pipe_d;
      dat_pipe_q <= dat_pipe_d;
      clk_prev_q <= clk_prev_d;
      fall_q     <= fall_d;
    end
  end

  assign dat_sync = dat_pipe_q[1];
  assign clk_fall = fall_q;

endmodule

// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host command sequencer: sends a command (plus optional argument) to the keyboard
// and handles line-ack, ACK/RESEND responses, retries and per-state timeouts.
module ps2_host_cmd_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] arg_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       rx_enable,
  output logic       busy,
  output logic       done,
  output logic [1:0] err
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int unsigned IDX_W   = 4;

  ps2_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic [7:0]         arg_q, arg_d;
  logic               arg_pending_q, arg_pending_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               clk_low_q, clk_low_d;
  logic               dat_low_q, dat_low_d;
  logic               rx_en_q, rx_en_d;
  logic               done_q, done_d;
  ps2_err_t           err_q, err_d;

  logic       dat_sync, clk_fall;
  logic [9:0] frame_c;
  logic       timeout_c;
  logic       fin;
  ps2_err_t   fin_code;

  ps2_line_sync u_line_sync (
    .clk        (CLOCK),
    .rst        (rst),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .dat_sync   (dat_sync),
    .clk_fall   (clk_fall)
  );

  assign frame_c   = ps2_frame(tx_byte_q);
  assign timeout_c = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d       = state_q;
    tx_byte_d     = tx_byte_q;
    arg_d         = arg_q;
    arg_pending_d = arg_pending_q;
    retry_d       = retry_q;
    idx_d         = idx_q;
    dat_low_d     = dat_low_q;
    err_d         = err_q;
    done_d        = 1'b0;
    fin           = 1'b0;
    fin_code      = ERR_OK;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          tx_byte_d     = cmd_byte;
          arg_pending_d = cmd_has_arg;
          arg_d         = arg_byte;
          retry_d       = '0;
          err_d         = ERR_OK;
          state_d       = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          state_d   = START;
          dat_low_d = 1'b1;
        end
      end
      START: begin
        idx_d = '0;
        if (timeout_c) begin
          fin      = 1'b1;
          fin_code = ERR_TIMEOUT;
        end else begin
          state_d = TX_BITS;
        end
      end
      // A device clock fall takes priority over an expiring timeout.
      TX_BITS: begin
        if (clk_fall) begin
          dat_low_d = ~frame_c[idx_q];
          idx_d     = IDX_W'(idx_q + IDX_W'(1));
          if (idx_q == IDX_W'(9)) begin
            dat_low_d = 1'b0;
            state_d   = WAIT_LINEACK;
          end
        end else if (timeout_c) begin
          fin      = 1'b1;
          fin_code = ERR_TIMEOUT;
        end
      end
      WAIT_LINEACK: begin
        if (clk_fall) begin
          if (!dat_sync) begin
            state_d = WAIT_RESP;
          end else begin
            fin      = 1'b1;
            fin_code = ERR_NOLINEACK;
          end
        end else if (timeout_c) begin
          fin      = 1'b1;
          fin_code = ERR_TIMEOUT;
        end
      end
      WAIT_RESP: begin
        if (rx_valid) begin
          if (rx_byte == PS2_ACK) begin
            if (arg_pending_q) begin
              tx_byte_d     = arg_q;
              arg_pending_d = 1'b0;
              retry_d       = '0;
              state_d       = INHIBIT;
            end else begin
              fin      = 1'b1;
              fin_code = ERR_OK;
            end
          end else if (rx_byte == PS2_RESEND) begin
            if (retry_q < RETRY_W'(MAX_RETRY)) begin
              retry_d = RETRY_W'(retry_q + RETRY_W'(1));
              state_d = INHIBIT;
            end else begin
              fin      = 1'b1;
              fin_code = ERR_RETRY;
            end
          end
        end else if (timeout_c) begin
          fin      = 1'b1;
          fin_code = ERR_TIMEOUT;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fin) begin
      state_d   = FINISH;
      err_d     = fin_code;
      done_d    = 1'b1;
      dat_low_d = 1'b0;
    end

    cnt_d     = ((state_d != state_q) || (state_q == IDLE)) ? '0 : CNT_W'(cnt_q + CNT_W'(1));
    clk_low_d = (state_d == INHIBIT) || (state_d == START);
    rx_en_d   = (state_d == IDLE) || (state_d == WAIT_RESP) || (state_d == FINISH);
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tx_byte_q     <= '0;
      arg_q         <= '0;
      arg_pending_q <= 1'b0;
      retry_q       <= '0;
      idx_q         <= '0;
      clk_low_q     <= 1'b0;
      dat_low_q     <= 1'b0;
      rx_en_q       <= 1'b1;
      done_q        <= 1'b0;
      err_q         <= ERR_OK;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tx_byte_q     <= tx_byte_d;
      arg_q         <= arg_d;
      arg_pending_q <= arg_pending_d;
      retry_q       <= retry_d;
      idx_q         <= idx_d;
      clk_low_q     <= clk_low_d;
      dat_low_q     <= dat_low_d;
      rx_en_q       <= rx_en_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign cmd_ready         = (state_q == IDLE);
  assign busy              = (state_q != IDLE);
  assign ps2_clk_drive_low = clk_low_q;
  assign ps2_dat_drive_low = dat_low_q;
  assign rx_enable         = rx_en_q;
  assign done              = done_q;
  assign err               = err_q;

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// Scoreboard bench for ps2_host_cmd_ctrl with a keyboard model on open-drain lines.
module tb_ps2_host_cmd_ctrl;

  localparam int unsigned INH  = 20;
  localparam int unsigned TMO  = 4000;
  localparam int unsigned MR   = 3;
  localparam int          HALF = 8;

  logic       CLOCK = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_byte = 8'h00;
  logic       cmd_has_arg = 1'b0;
  logic [7:0] arg_byte = 8'h00;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_drive_low, ps2_dat_drive_low;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_enable, busy, done;
  logic [1:0] err;

  logic kb_clk_low = 1'b0;
  logic kb_dat_low = 1'b0;

  assign ps2_clk_in = ~(kb_clk_low | ps2_clk_drive_low);
  assign ps2_dat_in = ~(kb_dat_low | ps2_dat_drive_low);

  always #5 CLOCK = ~CLOCK;

  ps2_host_cmd_ctrl #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRY      (MR)
  ) dut (
    .CLOCK             (CLOCK),
    .rst               (rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_byte          (cmd_byte),
    .cmd_has_arg       (cmd_has_arg),
    .arg_byte          (arg_byte),
    .ps2_clk_in        (ps2_clk_in),
    .ps2_dat_in        (ps2_dat_in),
    .ps2_clk_drive_low (ps2_clk_drive_low),
    .ps2_dat_drive_low (ps2_dat_drive_low),
    .rx_valid          (rx_valid),
    .rx_byte           (rx_byte),
    .rx_enable         (rx_enable),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [9:0] exp_frame_q[$];
  logic [1:0] exp_err_q[$];
  logic [7:0] resp_q[$];

  // 0 = normal keyboard, 1 = never clocks, 2 = withholds line-ack
  int bfm_mode = 0;
  bit bfm_abort = 1'b0;
  bit bfm_active = 1'b0;
  int bfm_bit = -1;
  int tx_count = 0;
  int inh_run = 0, inh_phases = 0, st_run = 0;
  int start_cyc = 0, done_cyc = 0;

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Keyboard receive of one host frame, line-ack, then optional response byte.
  task automatic bfm_frame();
    logic [9:0] got = '0;
    bit aborted = 1'b0;
    for (int k = 0; k < 10 && !aborted; k++) begin
      bfm_bit = k;
      repeat (HALF) @(negedge CLOCK);
      kb_clk_low = 1'b1;
      repeat (HALF) @(negedge CLOCK);
      kb_clk_low = 1'b0;
      got[k] = ps2_dat_in;
      if (bfm_abort) aborted = 1'b1;
    end
    bfm_bit = -1;
    if (!aborted) begin
      repeat (HALF) @(negedge CLOCK);
      if (bfm_mode != 2) kb_dat_low = 1'b1;
      repeat (HALF) @(negedge CLOCK);
      kb_clk_low = 1'b1;
      repeat (HALF) @(negedge CLOCK);
      kb_clk_low = 1'b0;
      kb_dat_low = 1'b0;
      tx_count++;
      if (exp_frame_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_frame: got 0x%0h, no frame was expected", got);
      end else begin
        chk("frame", int'(got), int'(exp_frame_q.pop_front()));
      end
      if (bfm_mode == 0 && resp_q.size() > 0) begin
        repeat (4) @(negedge CLOCK);
        chk("rx_enable_at_resp", int'(rx_enable), 1);
        rx_byte  = resp_q.pop_front();
        rx_valid = 1'b1;
        @(negedge CLOCK);
        rx_valid = 1'b0;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge CLOCK);
      if (bfm_mode != 1 && !bfm_abort && busy && !ps2_clk_drive_low && ps2_dat_drive_low) begin
        bfm_active = 1'b1;
        bfm_frame();
        bfm_active = 1'b0;
      end
    end
  end

  // Completion monitor: err against scoreboard, lines released, ready the next cycle.
  initial begin
    forever begin
      @(negedge CLOCK);
      if (done) begin
        done_cyc = cyc;
        if (exp_err_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: err=%0d, no completion was expected", err);
        end else begin
          chk("done_err", int'(err), int'(exp_err_q.pop_front()));
        end
        chk("done_lines_released", int'({ps2_clk_drive_low, ps2_dat_drive_low}), 0);
        @(negedge CLOCK);
        chk("ready_after_done", int'(cmd_ready), 1);
      end
    end
  end

  // Inhibit and start-bit phase length monitor.
  initial begin
    forever begin
      @(negedge CLOCK);
      if (ps2_clk_drive_low && !ps2_dat_drive_low) begin
        inh_run++;
      end else begin
        if (inh_run > 0) begin
          chk("inhibit_len", inh_run, int'(INH));
          inh_phases++;
        end
        inh_run = 0;
      end
      if (ps2_clk_drive_low && ps2_dat_drive_low) begin
        if (st_run == 0) start_cyc = cyc;
        st_run++;
      end else begin
        if (st_run > 0) chk("start_len", st_run, 1);
        st_run = 0;
      end
    end
  end

  initial begin
    repeat (60000) @(posedge CLOCK);
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [7:0] c, input bit has, input logic [7:0] a);
    int n = 0;
    @(negedge CLOCK);
    while (!cmd_ready && n < 10000) begin
      @(negedge CLOCK);
      n++;
    end
    cmd_valid   = 1'b1;
    cmd_byte    = c;
    cmd_has_arg = has;
    arg_byte    = a;
    @(negedge CLOCK);
    cmd_valid   = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge CLOCK);
      n++;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
    repeat (3) @(negedge CLOCK);
  endtask

  initial begin
    int tx0, inh0, rx_hi, lat, n;

    // Reset state
    repeat (3) @(negedge CLOCK);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_lines", int'({ps2_clk_drive_low, ps2_dat_drive_low}), 0);
    chk("rst_rx_enable", int'(rx_enable), 1);
    chk("rst_done_err", int'({done, err}), 0);
    rst = 1'b0;
    repeat (3) @(negedge CLOCK);

    // 1: ED + 02, both acknowledged; a command presented while busy is dropped
    tx0 = tx_count; inh0 = inh_phases;
    exp_frame_q.push_back(10'h3ED);
    exp_frame_q.push_back(10'h202);
    resp_q.push_back(8'hFA);
    resp_q.push_back(8'hFA);
    exp_err_q.push_back(2'b00);
    issue(8'hED, 1'b1, 8'h02);
    chk("t1_busy", int'(busy), 1);
    chk("t1_ready_while_busy", int'(cmd_ready), 0);
    cmd_valid = 1'b1; cmd_byte = 8'h55; cmd_has_arg = 1'b0;
    repeat (3) @(negedge CLOCK);
    cmd_valid = 1'b0;
    wait_done(3000, "t1_done");
    chk("t1_tx_count", tx_count - tx0, 2);
    chk("t1_inhibit_phases", inh_phases - inh0, 2);

    // 2: F4, resend once then ack
    tx0 = tx_count;
    exp_frame_q.push_back(10'h2F4);
    exp_frame_q.push_back(10'h2F4);
    resp_q.push_back(8'hFE);
    resp_q.push_back(8'hFA);
    exp_err_q.push_back(2'b00);
    issue(8'hF4, 1'b0, 8'h00);
    wait_done(3000, "t2_done");
    chk("t2_tx_count", tx_count - tx0, 2);

    // 3: F4, keyboard always asks for resend
    tx0 = tx_count;
    for (int i = 0; i < 4; i++) begin
      exp_frame_q.push_back(10'h2F4);
      resp_q.push_back(8'hFE);
    end
    exp_err_q.push_back(2'b10);
    issue(8'hF4, 1'b0, 8'h00);
    wait_done(5000, "t3_done");
    chk("t3_tx_count", tx_count - tx0, 4);

    // 4: FF, keyboard never clocks
    bfm_mode = 1;
    exp_err_q.push_back(2'b01);
    issue(8'hFF, 1'b0, 8'h00);
    wait_done(6000, "t4_done");
    lat = done_cyc - start_cyc;
    n_cmp++;
    if (lat < 3999 || lat > 4003) begin
      n_err++;
      $display("FAIL t4_timeout_latency: got %0d cycles, expected about %0d", lat, TMO);
    end
    bfm_mode = 0;

    // 5: line-ack withheld
    bfm_mode = 2;
    exp_frame_q.push_back(10'h2F4);
    exp_err_q.push_back(2'b11);
    issue(8'hF4, 1'b0, 8'h00);
    rx_hi = 0; n = 0;
    while (!done && n < 3000) begin
      if (rx_enable) rx_hi++;
      @(negedge CLOCK);
      n++;
    end
    chk("t5_rx_enable_high_cycles", rx_hi, 0);
    wait_done(10, "t5_done");
    bfm_mode = 0;

    // 6: reset while bit 4 is on the wire, then a clean ED/02
    issue(8'hED, 1'b1, 8'h02);
    n = 0;
    while (bfm_bit != 4 && n < 2000) begin
      @(negedge CLOCK);
      n++;
    end
    repeat (HALF + 4) @(negedge CLOCK);
    bfm_abort = 1'b1;
    rst = 1'b1;
    @(negedge CLOCK);
    rst = 1'b0;
    chk("t6_lines_released", int'({ps2_clk_drive_low, ps2_dat_drive_low}), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_rx_enable", int'(rx_enable), 1);
    chk("t6_done_err", int'({done, err}), 0);
    n = 0;
    while (bfm_active && n < 200) begin
      @(negedge CLOCK);
      n++;
    end
    bfm_abort = 1'b0;
    repeat (10) @(negedge CLOCK);
    exp_frame_q.push_back(10'h3ED);
    exp_frame_q.push_back(10'h202);
    resp_q.push_back(8'hFA);
    resp_q.push_back(8'hFA);
    exp_err_q.push_back(2'b00);
    issue(8'hED, 1'b1, 8'h02);
    wait_done(3000, "t6_done");

    repeat (20) @(negedge CLOCK);
    chk("left_frames", exp_frame_q.size(), 0);
    chk("left_dones", exp_err_q.size(), 0);
    chk("left_responses", resp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
